pin_verifier_scan: RTL and testbench
====================================

// Module: pin_verifier_scan
// PURPOSE
//  Parametrised PIN verifier for the door-lock keypad path. Captures a completed PIN entry,
//  checks it against the master PIN, or the factory default while unprovisioned, then scans the
//  enabled user PINs one per cycle. Emits a one-cycle classified result for the lock-control FSM.
//  Counts consecutive failures and can lock the keypad out (PIN_LOCKOUT_EN).
// PARAMETERS
//  N_DIGITS     4        digits per PIN
//  DIGIT_W      4        bits per digit
//  N_USERS      4        user PIN slots (>=1)
//  DEFAULT_PIN  'h1234   factory PIN, N_DIGITS*DIGIT_W bits, accepted only while master_set=0
//  MAX_FAILS    3        consecutive failures that trigger lockout (>=1)
//  LOCK_CYCLES  1000     lockout duration in clk cycles (>=1)
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    asynchronous, active-high reset
//  pin_valid  in   1                    entry complete; only its rising edge starts a check
//  pin_in     in   N_DIGITS*DIGIT_W     entered PIN; digit k at [k*DIGIT_W +: DIGIT_W]
//  master_pin in   N_DIGITS*DIGIT_W     programmed master PIN
//  master_set in   1                    master PIN has been provisioned
//  user_pins  in   N_USERS*N_DIGITS*DIGIT_W  slot u at [u*PW +: PW], PW=N_DIGITS*DIGIT_W
//  user_en    in   N_USERS              slot u is valid
//  busy       out  1                    check or lockout in progress
//  res_valid  out  1                    one-cycle result strobe
//  res_fail   out  1                    no match (qualified by res_valid)
//  res_user   out  1                    user slot matched
//  res_master out  1                    master PIN matched (master_set=1)
//  res_setup  out  1                    default PIN matched while master_set=0
//  res_idx    out  max(1,$clog2(N_USERS))  matched user slot, 0 otherwise
//  fail_cnt   out  $clog2(MAX_FAILS+1)  consecutive failures
//  locked     out  1                    lockout active
// BEHAVIOUR
//  - Reset: every output is 0. FSM=IDLE, capture register cleared, pin_valid edge register=0.
//    Reset mid-check or mid-lockout aborts immediately and no result is emitted.
//  - Edge detect: pv_d<=pin_valid every cycle, in every state. Start = pin_valid & ~pv_d & IDLE.
//    An edge seen outside IDLE is dropped, not queued. A held-high level never retriggers.
//  - FSM: IDLE -> MASTER -> SCAN -> RESULT -> IDLE|LOCKOUT.
//    IDLE:   on start, latch pin_in into cap. busy<=1. Go to MASTER.
//    MASTER: if master_set=0: cap==DEFAULT_PIN -> RESULT(setup), else RESULT(fail).
//            If master_set=1: cap==master_pin -> RESULT(master), else go to SCAN with idx=0.
//    SCAN:   each cycle compare cap with slot idx, gated by user_en[idx].
//            Match -> RESULT(user, res_idx=idx). Else if idx==N_USERS-1 -> RESULT(fail).
//            Else idx<=idx+1.
//    RESULT: res_valid and its one-hot class flag are high for exactly this cycle.
//            Then IDLE, or LOCKOUT if fail_cnt reached MAX_FAILS.
//  - Priority: master beats user. On duplicate user PINs, the lowest slot wins.
//  - Latency (start edge = E0): master/setup/default-fail result at E2, user slot u at E(3+u),
//    scan fail at E(2+N_USERS). busy stays high from E1 until the cycle after RESULT.
//  - fail_cnt: +1 on each fail result, saturating at MAX_FAILS. Cleared on any success.
//  - Inputs master_pin, user_pins and user_en are sampled live during MASTER/SCAN.
//    Changes mid-scan take effect from the next compared slot.
// CONFIGURATION
//  PIN_LOCKOUT_EN defined:
//    - When a fail makes fail_cnt==MAX_FAILS, RESULT is followed by LOCKOUT.
//    - In LOCKOUT, locked=1 and busy=1, and all pin_valid edges are dropped.
//    - After exactly LOCK_CYCLES cycles: go to IDLE, locked<=0, fail_cnt<=0.
//  PIN_LOCKOUT_EN undefined:
//    - No LOCKOUT state; locked is tied to 0.
//    - fail_cnt still counts and saturates at MAX_FAILS.
// TESTING (N_USERS=4, DIGIT_W=4, N_DIGITS=4, MAX_FAILS=3, LOCK_CYCLES=8)
//  1. master_set=0, pin_in='h1234, pulse pin_valid -> res_valid+res_setup at E2; fail_cnt=0.
//  2. master_set=1, master_pin='h9999, slot2='h4321, en=4'b0100, enter 'h4321
//     -> res_user=1, res_idx=2 at E5.
//  3. Slot1=slot3='h5555, both enabled, enter 'h5555 -> res_idx=1. Then set en[1]=0 and
//     re-enter -> res_idx=3.
//  4. Three wrong entries 'h0000 -> res_fail x3, fail_cnt=3. With PIN_LOCKOUT_EN, locked=1 for
//     8 cycles; an entry during lockout produces no res_valid; afterwards fail_cnt=0.
//  5. Hold pin_valid high 20 cycles -> exactly one result. Edge while busy -> dropped.
//  6. Assert rst during SCAN -> all outputs 0 next cycle, no res_valid. A new entry then works.

Source files
------------

// File: rtl/pin_verifier_scan.sv
// Keypad PIN verifier: captures an entry, checks factory/master PIN, then scans user slots one per cycle.
// Optional lockout after MAX_FAILS consecutive failures is enabled by defining PIN_LOCKOUT_EN.
//
// state   | meaning
// IDLE    | waiting for a pin_valid rising edge
// MASTER  | compare capture against master PIN (or factory PIN while unprovisioned)
// SCAN    | compare capture against user slot idx, one slot per cycle
// RESULT  | result strobe visible for this cycle
// LOCKOUT | keypad ignored for LOCK_CYCLES cycles (PIN_LOCKOUT_EN only)
module pin_verifier_scan #(
    parameter int N_DIGITS = 4,
    parameter int DIGIT_W  = 4,
    parameter int N_USERS  = 4,
    parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_PIN = 'h1234,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1000,
    localparam int PW = N_DIGITS * DIGIT_W,
    localparam int IW = (N_USERS > 1) ? $clog2(N_USERS) : 1,
    localparam int FW = $clog2(MAX_FAILS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pin_valid,
    input  logic [PW-1:0]         pin_in,
    input  logic [PW-1:0]         master_pin,
    input  logic                  master_set,
    input  logic [N_USERS*PW-1:0] user_pins,
    input  logic [N_USERS-1:0]    user_en,
    output logic                  busy,
    output logic                  res_valid,
    output logic                  res_fail,
    output logic                  res_user,
    output logic                  res_master,
    output logic                  res_setup,
    output logic [IW-1:0]         res_idx,
    output logic [FW-1:0]         fail_cnt,
    output logic                  locked
);

`ifdef PIN_LOCKOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_MASTER, S_SCAN, S_RESULT, S_LOCKOUT
    } state_t;
    localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    logic [TW-1:0] timer;
`else
    typedef enum logic [1:0] {
        S_IDLE, S_MASTER, S_SCAN, S_RESULT
    } state_t;
`endif

    localparam logic [IW-1:0] LAST_IDX = IW'(N_USERS - 1);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAILS);

    state_t        state;
    logic          pv_d;
    logic [PW-1:0] cap;
    logic [IW-1:0] idx;
    logic [PW-1:0] slot_pin [N_USERS];
    logic          start;
    logic          slot_hit;
    logic [FW-1:0] fail_next;

    for (genvar u = 0; u < N_USERS; u++) begin : g_slot
        assign slot_pin[u] = user_pins[u*PW +: PW];
    end

    // Only a rising edge seen while idle starts a check; anything else is dropped.
    assign start     = pin_valid & ~pv_d & (state == S_IDLE);
    assign slot_hit  = user_en[idx] & (cap == slot_pin[idx]);
    assign fail_next = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pv_d       <= 1'b0;
            cap        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_fail   <= 1'b0;
            res_user   <= 1'b0;
            res_master <= 1'b0;
            res_setup  <= 1'b0;
            res_idx    <= '0;
            fail_cnt   <= '0;
            locked     <= 1'b0;
`ifdef PIN_LOCKOUT_EN
            timer      <= '0;
`endif
        end else begin
            pv_d <= pin_valid;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cap   <= pin_in;
                        busy  <= 1'b1;
                        state <= S_MASTER;
                    end
                end
                S_MASTER: begin
                    if (!master_set) begin
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                        if (cap == DEFAULT_PIN) begin
                            res_setup <= 1'b1;
                            fail_cnt  <= '0;
                        end else begin
                            res_fail <= 1'b1;
                            fail_cnt <= fail_next;
                        end
                    end else if (cap == master_pin) begin
                        res_valid  <= 1'b1;
                        res_master <= 1'b1;
                        fail_cnt   <= '0;
                        state      <= S_RESULT;
                    end else begin
                        idx   <= '0;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (slot_hit) begin
                        res_valid <= 1'b1;
                        res_user  <= 1'b1;
                        res_idx   <= idx;
                        fail_cnt  <= '0;
                        state     <= S_RESULT;
                    end else if (idx == LAST_IDX) begin
                        res_valid <= 1'b1;
                        res_fail  <= 1'b1;
                        fail_cnt  <= fail_next;
                        state     <= S_RESULT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_RESULT: begin
                    res_valid  <= 1'b0;
                    res_fail   <= 1'b0;
                    res_user   <= 1'b0;
                    res_master <= 1'b0;
                    res_setup  <= 1'b0;
                    res_idx    <= '0;
`ifdef PIN_LOCKOUT_EN
                    if (res_fail && fail_cnt == FAIL_MAX) begin
                        locked <= 1'b1;
                        timer  <= TW'(LOCK_CYCLES - 1);
                        state  <= S_LOCKOUT;
                    end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
`else
                    busy  <= 1'b0;
                    state <= S_IDLE;
`endif
                end
`ifdef PIN_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (timer == '0) begin
                        locked   <= 1'b0;
                        busy     <= 1'b0;
                        fail_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_verifier_scan.sv
// Directed and randomized checks of pin_verifier_scan against a rule-level reference model.
module tb_pin_verifier_scan;
    localparam int NU = 4;
    localparam int PW = 16;
    localparam int MF = 3;
    localparam int LC = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            pin_valid;
    logic [PW-1:0]   pin_in;
    logic [PW-1:0]   master_pin;
    logic            master_set;
    logic [NU*PW-1:0] user_pins;
    logic [NU-1:0]   user_en;
    logic            busy, res_valid, res_fail, res_user, res_master, res_setup, locked;
    logic [1:0]      res_idx;
    logic [1:0]      fail_cnt;

    int checks   = 0;
    int failures = 0;
    int fails_m  = 0;

    always #5 clk = ~clk;

    pin_verifier_scan #(
        .N_DIGITS(4), .DIGIT_W(4), .N_USERS(NU), .DEFAULT_PIN(16'h1234),
        .MAX_FAILS(MF), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .rst(rst), .pin_valid(pin_valid), .pin_in(pin_in),
        .master_pin(master_pin), .master_set(master_set), .user_pins(user_pins),
        .user_en(user_en), .busy(busy), .res_valid(res_valid), .res_fail(res_fail),
        .res_user(res_user), .res_master(res_master), .res_setup(res_setup),
        .res_idx(res_idx), .fail_cnt(fail_cnt), .locked(locked)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {21'd0, busy, res_valid, res_fail, res_user, res_master, res_setup,
                res_idx, fail_cnt, locked};
    endfunction

    // flags = {fail, user, master, setup}; lat = edge (after the start edge) at which the strobe is sampled
    function automatic void model(input logic [PW-1:0] p, output logic [3:0] flags,
                                  output int idx, output int lat);
        flags = 4'b1000;
        idx   = 0;
        if (!master_set) begin
            lat   = 2;
            flags = (p == 16'h1234) ? 4'b0001 : 4'b1000;
        end else if (p == master_pin) begin
            lat   = 2;
            flags = 4'b0010;
        end else begin
            lat = 2 + NU;
            for (int u = NU - 1; u >= 0; u--) begin
                if (user_en[u] && user_pins[u*PW +: PW] == p) begin
                    flags = 4'b0100;
                    idx   = u;
                    lat   = 3 + u;
                end
            end
        end
    endfunction

    task automatic set_slot(input int u, input logic [PW-1:0] v);
        user_pins[u*PW +: PW] = v;
    endtask

    task automatic run_entry(input string tag, input logic [PW-1:0] p);
        logic [3:0] ef;
        int ei, el, n;
        bit found, lock_exp;
        model(p, ef, ei, el);
        @(negedge clk);
        pin_in    = p;
        pin_valid = 1'b1;
        @(posedge clk);
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (res_valid) found = 1'b1;
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            chk({tag, "_lat"}, n + 1, el);
            chk({tag, "_class"}, {28'd0, res_fail, res_user, res_master, res_setup}, {28'd0, ef});
            chk({tag, "_idx"}, 32'(res_idx), ei);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        fails_m = ef[3] ? ((fails_m < MF) ? fails_m + 1 : MF) : 0;
        chk({tag, "_fcnt"}, 32'(fail_cnt), fails_m);
        lock_exp = 1'b0;
`ifdef PIN_LOCKOUT_EN
        lock_exp = ef[3] && (fails_m == MF);
`endif
        @(negedge clk);
        pin_valid = 1'b0;
        if (lock_exp) begin
            for (int i = 0; i < LC; i++) begin
                @(posedge clk);
                #1;
                chk({tag, "_locked"}, 32'(locked), 32'd1);
                chk({tag, "_lock_nores"}, 32'(res_valid), 32'd0);
                pin_valid = (i == 1 || i == 2);
            end
            @(posedge clk);
            #1;
            fails_m = 0;
            chk({tag, "_unlock"}, {29'd0, locked, busy, res_valid}, 32'd0);
            chk({tag, "_fcnt_clr"}, 32'(fail_cnt), 32'd0);
        end else begin
            @(posedge clk);
            #1;
            chk({tag, "_after"}, {29'd0, locked, busy, res_valid}, 32'd0);
        end
    endtask

    initial begin
        int nres;
        logic [PW-1:0] p;
        rst        = 1'b1;
        pin_valid  = 1'b0;
        pin_in     = '0;
        master_pin = '0;
        master_set = 1'b0;
        user_pins  = '0;
        user_en    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", all_outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // factory PIN while unprovisioned
        run_entry("setup", 16'h1234);
        run_entry("setup_wrong", 16'h4321);
        run_entry("setup_ok", 16'h1234);

        // single enabled user slot
        master_set = 1'b1;
        master_pin = 16'h9999;
        set_slot(0, 16'h1111); set_slot(1, 16'h2222);
        set_slot(2, 16'h4321); set_slot(3, 16'h3333);
        user_en = 4'b0100;
        run_entry("user2", 16'h4321);
        run_entry("master", 16'h9999);

        // duplicate slots: lowest enabled wins
        set_slot(1, 16'h5555); set_slot(3, 16'h5555);
        user_en = 4'b1010;
        run_entry("dup_low", 16'h5555);
        user_en = 4'b1000;
        run_entry("dup_high", 16'h5555);

        // consecutive failures, lockout when enabled
        user_en = 4'b1111;
        run_entry("bad1", 16'h0000);
        run_entry("bad2", 16'h0000);
        run_entry("bad3", 16'h0000);
        run_entry("bad4", 16'h0000);
        run_entry("recover", 16'h9999);

        // held level gives one result; a re-edge while busy is dropped
        @(negedge clk);
        pin_in    = 16'h9999;
        pin_valid = 1'b1;
        nres = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (res_valid) nres++;
        end
        chk("hold_once", nres, 1);
        @(negedge clk);
        pin_valid = 1'b0;
        user_en   = 4'b1000;
        @(negedge clk);
        pin_in    = 16'h5555;
        pin_valid = 1'b1;
        @(negedge clk);
        pin_valid = 1'b0;
        @(negedge clk);
        pin_valid = 1'b1;
        nres = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (res_valid) nres++;
        end
        chk("busy_drop", nres, 1);
        chk("busy_drop_fcnt", 32'(fail_cnt), 32'd0);
        fails_m = 0;
        @(negedge clk);
        pin_valid = 1'b0;
        @(negedge clk);

        // reset in the middle of a scan
        user_en = 4'b0000;
        @(negedge clk);
        pin_in    = 16'h0000;
        pin_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_scan", all_outs(), 32'd0);
        @(negedge clk);
        pin_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        fails_m = 0;
        nres = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (res_valid) nres++;
        end
        chk("rst_no_result", nres, 0);
        user_en = 4'b0010;
        run_entry("post_rst", 16'h5555);

        // randomized entries against the model
        for (int k = 0; k < 40; k++) begin
            master_set = ($urandom_range(0, 3) != 0);
            master_pin = 16'($urandom);
            for (int u = 0; u < NU; u++) set_slot(u, 16'($urandom_range(0, 15) * 16'h1111));
            user_en = 4'($urandom);
            case ($urandom_range(0, 4))
                0: p = master_pin;
                1: p = 16'h1234;
                2: p = user_pins[$urandom_range(0, NU - 1)*PW +: PW];
                3: p = 16'($urandom);
                default: p = 16'h0000;
            endcase
            run_entry($sformatf("rand%0d", k), p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
